// File: rtl/number_to_code_tx_pkg.sv
// Shared types and code constants for the number-to-code transmitter and its decoder.
package number_to_code_tx_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned HoldCntW = 8;

    localparam logic [3:0] CodeNone = 4'b0000;
    localparam logic [3:0] Code0    = 4'b0001;
    localparam logic [3:0] Code1    = 4'b0010;
    localparam logic [3:0] Code2    = 4'b0011;
    localparam logic [3:0] Code3    = 4'b0100;

    function automatic logic [3:0] num_to_code(input logic [1:0] num);
        logic [3:0] code;
        code = CodeNone;
        unique case (num)
            2'd0: code = Code0;
            2'd1: code = Code1;
            2'd2: code = Code2;
            2'd3: code = Code3;
            default: code = CodeNone;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/number_fifo.sv
// Small power-of-two FIFO with synchronous flush; head entry is read straight from
// the storage registers so the consumer can load it on the popping edge.
module number_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push, do_pop;

    // Full/empty guards live here so a misbehaving producer cannot corrupt state.
    assign do_push = push_i && !flush_i && (level_q != FullLvl);
    assign do_pop  = pop_i && !flush_i && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/number_to_code_tx.sv
// Queues 2-bit numbers and drives each as a 4-bit code for HOLD_CYCLES cycles,
// followed by a one-cycle zero gap that carries the done pulse.
module number_to_code_tx
    import number_to_code_tx_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [1:0]                  Number,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [3:0]                  BCD,
    output logic                        code_valid,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LvlW-1:0]     FullLvl  = LvlW'(FIFO_DEPTH);
    localparam logic [HoldCntW-1:0] HoldLoad = HoldCntW'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                code_valid_q, code_valid_d;
    logic                done_q, done_d;

    logic                fifo_push, fifo_pop;
    logic [1:0]          head_num;
    logic [LvlW-1:0]     fifo_level;

    // Ready looks only at registered occupancy; a pop on the same edge does not help.
    assign in_ready  = (fifo_level != FullLvl) && !flush;
    assign fifo_push = in_valid && in_ready;

    number_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .data_i  (Number),
        .data_o  (head_num),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        bcd_d        = bcd_q;
        code_valid_d = code_valid_q;
        done_d       = 1'b0;
        fifo_pop     = 1'b0;
        if (flush) begin
            state_d      = StIdle;
            hold_cnt_d   = '0;
            bcd_d        = CodeNone;
            code_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo_level != '0) begin
                        fifo_pop     = 1'b1;
                        bcd_d        = num_to_code(head_num);
                        code_valid_d = 1'b1;
                        hold_cnt_d   = HoldLoad;
                        state_d      = StHold;
                    end else begin
                        bcd_d        = CodeNone;
                        code_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == '0) begin
                        bcd_d        = CodeNone;
                        code_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = StGap;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d      = StIdle;
                    bcd_d        = CodeNone;
                    code_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            bcd_q        <= CodeNone;
            code_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            bcd_q        <= bcd_d;
            code_valid_q <= code_valid_d;
            done_q       <= done_d;
        end
    end

    assign BCD        = bcd_q;
    assign code_valid = code_valid_q;
    assign done       = done_q;
    assign level      = fifo_level;

endmodule

// File: tb/tb_number_to_code_tx.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic
// compared against a frame-based reference model of the transmitter.
module tb_number_to_code_tx;

    localparam int Hold  = 4;
    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, flush;
    logic [1:0] number;
    logic       in_ready, code_valid, done;
    logic [3:0] bcd;
    logic [2:0] level;

    logic       in_valid1;
    logic [1:0] number1;
    logic       in_ready1, code_valid1, done1;
    logic [3:0] bcd1;
    logic [2:0] level1;

    always #5 clk = ~clk;

    number_to_code_tx #(.HOLD_CYCLES(Hold), .FIFO_DEPTH(Depth)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Number(number),
        .in_ready(in_ready), .flush(flush), .BCD(bcd), .code_valid(code_valid),
        .done(done), .level(level)
    );

    number_to_code_tx #(.HOLD_CYCLES(1), .FIFO_DEPTH(Depth)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .Number(number1),
        .in_ready(in_ready1), .flush(flush), .BCD(bcd1), .code_valid(code_valid1),
        .done(done1), .level(level1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending numbers plus the position inside the
    // current value's frame (Hold code cycles, one gap cycle, then idle).
    int mq[$];
    int m_pos  = -1;
    int m_cur  = 0;
    bit m_init = 0;

    bit rdy_pre, xfer_pre;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_edge();
        bit push;
        push = in_valid && !flush && (mq.size() < Depth);
        if (!rst_n || flush) begin
            mq.delete();
            m_pos = -1;
            if (!rst_n) m_init = 1;
        end else begin
            if (m_pos < 0) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_pos = 0;
                end
            end else if (m_pos == Hold) begin
                m_pos = -1;
            end else begin
                m_pos++;
            end
            if (push) mq.push_back(int'(number));
        end
    endfunction

    task automatic check_outputs();
        int eb;
        eb = (m_pos >= 0 && m_pos < Hold) ? m_cur + 1 : 0;
        if (m_init) begin
            check("model_bcd", int'(bcd), eb);
            check("model_code_valid", int'(code_valid), int'(eb != 0));
            check("model_done", int'(done), int'(m_pos == Hold));
            check("model_level", int'(level), mq.size());
        end
    endtask

    task automatic tick();
        #1;
        rdy_pre  = in_ready;
        xfer_pre = in_valid && in_ready && !flush && rst_n;
        if (m_init) check("model_in_ready", int'(in_ready), int'(mq.size() != Depth && !flush));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic [1:0] n);
        rst_n = r; flush = f; in_valid = v; number = n;
    endtask

    typedef struct {
        logic       rst_n, flush, vld;
        logic [1:0] num;
        logic [3:0] bcd;
        logic       cv, dn;
        int         lvl;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int seq[$];
        int exp_seq[8];
        int last, peak, cv_cnt, xfers, dn_cnt;
        bit ready_when_full;
        int exp_b1[7];
        int exp_d1[7];

        drive(1'b0, 1'b0, 1'b0, 2'd0);
        in_valid1 = 1'b0;
        number1   = 2'd0;

        // Reset, then a single Number=2 through a full hold/gap/idle frame.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 0};

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst_n, tbl[i].flush, tbl[i].vld, tbl[i].num);
            tick();
            check($sformatf("tbl%0d_bcd", i), int'(bcd), int'(tbl[i].bcd));
            check($sformatf("tbl%0d_cv", i), int'(code_valid), int'(tbl[i].cv));
            check($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
            check($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        check("after_reset_in_ready", int'(in_ready), 1);

        // Back-to-back 0,1,2,3.
        exp_seq = '{1, 0, 2, 0, 3, 0, 4, 0};
        last = 0; peak = 0; cv_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 4) drive(1'b1, 1'b0, 1'b1, 2'(i));
            else       drive(1'b1, 1'b0, 1'b0, 2'd0);
            tick();
            if (i < 4) check($sformatf("b2b_ready%0d", i), int'(rdy_pre), 1);
            if (int'(level) > peak) peak = int'(level);
            if (code_valid) cv_cnt++;
            if (int'(bcd) != last) begin
                seq.push_back(int'(bcd));
                last = int'(bcd);
            end
        end
        check("b2b_level_peak", peak, 3);
        check("b2b_code_cycles", cv_cnt, 16);
        check("b2b_seq_len", seq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < seq.size()) check($sformatf("b2b_seq%0d", i), seq[i], exp_seq[i]);
        end

        // Six cycles of in_valid while a value is holding.
        drive(1'b1, 1'b0, 1'b1, 2'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        check("fill_in_hold", int'(code_valid), 1);
        xfers = 0; peak = 0; ready_when_full = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 2'((i + 2) % 4));
            #1;
            if (int'(level) == Depth && in_ready) ready_when_full = 1;
            tick();
            if (xfer_pre) xfers++;
            if (int'(level) > peak) peak = int'(level);
        end
        check("fill_transfers", xfers, 4);
        check("fill_level_peak", peak, 4);
        check("fill_ready_when_full", int'(ready_when_full), 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 32; i++) tick();
        check("fill_drained", int'(level), 0);

        // Flush during hold with two queued and in_valid asserted.
        drive(1'b1, 1'b0, 1'b1, 2'd3); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd1); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2); tick();
        check("flush_pre_level", int'(level), 2);
        check("flush_pre_cv", int'(code_valid), 1);
        drive(1'b1, 1'b1, 1'b1, 2'd0);
        tick();
        check("flush_no_transfer", int'(xfer_pre), 0);
        check("flush_level", int'(level), 0);
        check("flush_bcd", int'(bcd), 0);
        check("flush_cv", int'(code_valid), 0);
        check("flush_done", int'(done), 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        dn_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || code_valid) dn_cnt++;
        end
        check("flush_quiet_after", dn_cnt, 0);

        // One-cycle reset in the middle of a hold.
        drive(1'b1, 1'b0, 1'b1, 2'd2); tick();
        drive(1'b1, 1'b0, 1'b1, 2'd1); tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0); tick();
        check("rst_pre_cv", int'(code_valid), 1);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("rst_bcd", int'(bcd), 0);
        check("rst_cv", int'(code_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_level", int'(level), 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        #1;
        check("rst_release_ready", int'(in_ready), 1);
        dn_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dn_cnt++;
        end
        check("rst_no_done", dn_cnt, 0);

        // HOLD_CYCLES=1 instance: Number=3 twice.
        exp_b1 = '{0, 4, 0, 0, 4, 0, 0};
        exp_d1 = '{0, 0, 1, 0, 0, 1, 0};
        dn_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid1 = (i < 2);
            number1   = 2'd3;
            tick();
            check($sformatf("h1_bcd%0d", i), int'(bcd1), exp_b1[i]);
            check($sformatf("h1_done%0d", i), int'(done1), exp_d1[i]);
            if (done1) dn_cnt++;
        end
        in_valid1 = 1'b0;
        check("h1_done_pulses", dn_cnt, 2);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/number_to_code_tx.md
NUMBER_TO_CODE_TX -- requirements
Module: number_to_code_tx

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles each code is driven on BCD; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: number of queued entries; a power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port in_valid, input, 1: Number is presented for transfer.
REQ-006 Port Number, input, 2: value 0..3 to encode.
REQ-007 Port in_ready, output, 1: the block can accept a value this cycle.
REQ-008 Port flush, input, 1: synchronous abort; discards queued and in-flight values.
REQ-009 Port BCD, output, 4: registered code output; 4'b0000 when idle.
REQ-010 Port code_valid, output, 1: BCD carries a valid code.
REQ-011 Port done, output, 1: one-cycle pulse when a code finishes its gap.
REQ-012 Port level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-013 Encoding SHALL be 0->4'b0001, 1->4'b0010, 2->4'b0011, 3->4'b0100 (code = Number+1, 4-bit zero-extended); no other value is driven while code_valid=1.
REQ-014 A transfer SHALL occur on any edge where in_valid=1, in_ready=1 and flush=0; Number is written to the FIFO tail.
REQ-015 in_ready SHALL equal (level != FIFO_DEPTH) && !flush, combinationally from registered state only; it does not depend on pops in the same cycle.
REQ-016 The FSM SHALL have the states IDLE, HOLD and GAP.
REQ-017 IDLE: when level>0, pop the head, load BCD with its code, set code_valid=1, load the hold counter with HOLD_CYCLES-1 and go to HOLD; otherwise BCD=0 and code_valid=0.
REQ-018 HOLD: decrement the counter; when it reaches 0, set BCD=0 and code_valid=0 and go to GAP.
REQ-019 GAP: lasts exactly 1 cycle with BCD=0; assert done for that cycle and go to IDLE. Back-to-back equal values are therefore separated by a zero code.
REQ-020 Latency: a value accepted into an empty FIFO with the FSM in IDLE at edge N SHALL appear on BCD after edge N+1.
REQ-021 A simultaneous push and pop SHALL leave level unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 A push attempted while full is not a transfer; data and level are unchanged.
REQ-023 flush=1 SHALL, at the next edge, empty the FIFO (level=0), force IDLE, and drive BCD=0, code_valid=0 and done=0. flush has priority over push and pop in the same cycle.
REQ-024 Per value, code_valid is high for exactly HOLD_CYCLES consecutive cycles. HOLD_CYCLES=1 gives a 1-cycle HOLD followed by GAP.

Reset
REQ-025 When rst_n=0 at an edge, the block SHALL set state=IDLE, level=0, pointers=0, counter=0, BCD=4'b0000, code_valid=0 and done=0.
REQ-026 Reset mid-HOLD SHALL abort the code immediately (the next cycle shows BCD=0), lose queued data, and produce no done pulse.
REQ-027 in_ready SHALL be 1 from the first cycle after reset is released.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/HOLD/GAP) and the four code constants; the existing decoder uses the same constants.
REQ-029 The FIFO SHALL be a separate sub-module number_fifo (push/pop/flush, registered data out, level), instantiated once.

Verification
REQ-030 Reset, then push Number=2 with HOLD_CYCLES=4 -> BCD=4'b0011 and code_valid=1 for 4 cycles from edge N+1, then 1 cycle of BCD=0 with done=1, then IDLE.
REQ-031 Push 0,1,2,3 back-to-back -> in_ready=1 for all four pushes, level peaks at 3; BCD sequence 0001,0000,0010,0000,0011,0000,0100,0000 with 4 code cycles per value.
REQ-032 Hold in_valid=1 for 6 cycles while the FSM is in HOLD -> exactly 4 transfers, in_ready=0 when level=4, no data corruption, and level stays 4 during the same-cycle push/pop after a pop.
REQ-033 Assert flush during HOLD with level=2 and in_valid=1 -> next cycle level=0, BCD=0, code_valid=0, no transfer, no done pulse.
REQ-034 Assert rst_n=0 for 1 cycle mid-HOLD -> all outputs at reset values the following cycle, and in_ready=1 after release.
REQ-035 Push Number=3 twice with HOLD_CYCLES=1 -> BCD 0100,0000,0100,0000 with done pulsing twice.
